// File: rtl/ifu_fetch_pkg.sv
// Shared core definitions: fetch FSM states and instruction-word constants.
package ifu_fetch_pkg;

  localparam int INST_W = 32;
  localparam logic [INST_W-1:0] INST_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    HOLD,
    FLUSH
  } fetch_state_e;

endpackage

// File: rtl/ifu_fetch.sv
// Multi-cycle fetch stage: one outstanding imem request, registered instruction buffer to decode.
// Optional perf counters (perf_fetch_cnt, perf_flush_cnt) are built when IFU_FETCH_PERF_EN is defined.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] PC_RST_VEC = 32'h8000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [XLEN-1:0]   imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  input  logic              imem_rsp_err,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [XLEN-1:0]   inst_pc,
  output logic              inst_fault
`ifdef IFU_FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_flush_cnt
`endif
);

  fetch_state_e      state_q;
  logic [XLEN-1:0]   fetch_pc_q;
  logic [XLEN-1:0]   fetch_pc_inc;
  logic              inst_valid_q;
  logic [INST_W-1:0] inst_q;
  logic [XLEN-1:0]   inst_pc_q;
  logic              inst_fault_q;

  logic pc_misaligned;
  logic req_fire;
  logic hold_stuck;

  assign pc_misaligned = |fetch_pc_q[1:0];
  assign fetch_pc_inc  = fetch_pc_q + XLEN'(4);
  assign req_fire      = imem_req_valid && imem_req_ready;
  // A misaligned-fetch fault cannot make progress; it stays presented until a redirect.
  assign hold_stuck    = inst_fault_q && (|inst_pc_q[1:0]);

  assign imem_req_valid = (state_q == REQ) && !pc_misaligned;
  assign imem_req_addr  = fetch_pc_q;

  assign inst_valid = inst_valid_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign inst_fault = inst_fault_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= REQ;
      fetch_pc_q   <= PC_RST_VEC;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_fault_q <= 1'b0;
    end else if (redirect) begin
      fetch_pc_q <= redirect_pc;
      case (state_q)
        REQ:     if (req_fire) state_q <= FLUSH;
        WAIT:    state_q <= imem_rsp_valid ? REQ : FLUSH;
        HOLD: begin
          inst_valid_q <= 1'b0;
          state_q      <= REQ;
        end
        FLUSH:   if (imem_rsp_valid) state_q <= REQ;
        default: state_q <= REQ;
      endcase
    end else begin
      case (state_q)
        REQ: begin
          if (pc_misaligned) begin
            inst_q       <= '0;
            inst_pc_q    <= fetch_pc_q;
            inst_fault_q <= 1'b1;
            inst_valid_q <= 1'b1;
            state_q      <= HOLD;
          end else if (imem_req_ready) begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            inst_q       <= imem_rsp_err ? '0 : imem_rsp_data;
            inst_pc_q    <= fetch_pc_q;
            inst_fault_q <= imem_rsp_err;
            inst_valid_q <= 1'b1;
            fetch_pc_q   <= fetch_pc_inc;
            state_q      <= HOLD;
          end
        end
        HOLD: begin
          if (inst_ready && !hold_stuck) begin
            inst_valid_q <= 1'b0;
            state_q      <= REQ;
          end
        end
        FLUSH:   if (imem_rsp_valid) state_q <= REQ;
        default: state_q <= REQ;
      endcase
    end
  end

`ifdef IFU_FETCH_PERF_EN
  logic        fetch_hs;
  logic        flush_ev;
  logic [31:0] perf_fetch_q;
  logic [31:0] perf_flush_q;

  assign fetch_hs = (state_q == HOLD) && inst_ready && !redirect && !hold_stuck;
  // Discarded responses and buffered instructions dropped by a redirect.
  assign flush_ev = (redirect && ((state_q == HOLD) || ((state_q == WAIT) && imem_rsp_valid)))
                 || ((state_q == FLUSH) && imem_rsp_valid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (fetch_hs) perf_fetch_q <= perf_fetch_q + 32'd1;
      if (flush_ev) perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: memory model + scoreboard, redirect vector table, hand-written corner sequences.
module tb_ifu_fetch;

  logic        clk;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;

  ifu_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_fault     (inst_fault)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
  } exp_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] err;
    int          lat;
    logic [31:0] exp_inst;
    logic        exp_fault;
    logic [31:0] exp_next;
  } vec_t;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  exp_t        exp_q[$];
  logic [31:0] req_log[$];
  int          req_cyc[$];
  int          hs_cyc[$];

  int          rsp_lat;
  logic [31:0] err_addr;
  bit          mis_hold;
  bit          mem_busy;
  int          mem_cnt;
  logic [31:0] mem_addr;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_req(output logic [31:0] addr);
    bit got = 0;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clk);
      got = imem_req_valid && imem_req_ready;
    end
    chk("req_handshake_seen", 32'(got), 32'd1);
    addr = imem_req_addr;
  endtask

  task automatic wait_inst();
    bit got = 0;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clk);
      got = inst_valid;
    end
    chk("inst_valid_seen", 32'(got), 32'd1);
  endtask

  // Memory model and scoreboard; everything is sampled on the falling edge.
  initial begin
    mem_busy = 0;
    mem_cnt  = 0;
    mem_addr = '0;
    imem_rsp_valid = 0;
    imem_rsp_data  = '0;
    imem_rsp_err   = 0;
    forever begin
      bit busy0;
      @(negedge clk);
      cyc++;
      busy0 = mem_busy;
      imem_rsp_valid = 0;
      imem_rsp_data  = '0;
      imem_rsp_err   = 0;
      if (mem_busy) begin
        if (mem_cnt == 0) begin
          imem_rsp_valid = 1;
          imem_rsp_data  = mem_word(mem_addr);
          imem_rsp_err   = (mem_addr == err_addr);
          mem_busy       = 0;
        end else begin
          mem_cnt--;
        end
      end
      if (rst) begin
        exp_q.delete();
      end else begin
        if (redirect) exp_q.delete();
        if (imem_req_valid && imem_req_ready) begin
          chk("one_outstanding", 32'(busy0), 32'd0);
          mem_busy = 1;
          mem_addr = imem_req_addr;
          mem_cnt  = rsp_lat - 1;
          req_log.push_back(imem_req_addr);
          req_cyc.push_back(cyc);
          if (!redirect) begin
            exp_t e;
            e.pc    = imem_req_addr;
            e.fault = (imem_req_addr == err_addr);
            e.inst  = e.fault ? 32'd0 : mem_word(imem_req_addr);
            exp_q.push_back(e);
          end
        end
        if (inst_valid && inst_ready && !redirect && !mis_hold) begin
          hs_cyc.push_back(cyc);
          chk("sb_has_expected", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("sb_inst_pc", inst_pc, e.pc);
            chk("sb_inst", inst, e.inst);
            chk("sb_inst_fault", 32'(inst_fault), 32'(e.fault));
          end
        end
      end
    end
  end

  initial begin
    vec_t        vecs[5];
    logic [31:0] a;
    logic [31:0] hold_pc;
    logic [31:0] hold_inst;
    int          gap;
    int          ivs;
    bit          got;

    rst = 1; redirect = 0; redirect_pc = '0;
    imem_req_ready = 0; inst_ready = 0;
    rsp_lat = 1; err_addr = 32'hFFFF_FFF0; mis_hold = 0;

    vecs[0] = '{pc: 32'h8000_0040, err: 32'hFFFF_FFF0, lat: 1,
                exp_inst: mem_word(32'h8000_0040), exp_fault: 1'b0, exp_next: 32'h8000_0044};
    vecs[1] = '{pc: 32'h8000_0010, err: 32'h8000_0010, lat: 1,
                exp_inst: 32'd0, exp_fault: 1'b1, exp_next: 32'h8000_0014};
    vecs[2] = '{pc: 32'hFFFF_FFFC, err: 32'hFFFF_FFF0, lat: 2,
                exp_inst: mem_word(32'hFFFF_FFFC), exp_fault: 1'b0, exp_next: 32'h0000_0000};
    vecs[3] = '{pc: 32'h0000_0000, err: 32'hFFFF_FFF0, lat: 3,
                exp_inst: mem_word(32'h0000_0000), exp_fault: 1'b0, exp_next: 32'h0000_0004};
    vecs[4] = '{pc: 32'h8000_0104, err: 32'h8000_0104, lat: 2,
                exp_inst: 32'd0, exp_fault: 1'b1, exp_next: 32'h8000_0108};

    // Reset values
    repeat (3) tick();
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_inst_fault", 32'(inst_fault), 32'd0);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd1);
    chk("rst_req_addr", imem_req_addr, 32'h8000_0000);

    // Zero-wait streaming: one instruction every third cycle
    req_log.delete(); req_cyc.delete(); hs_cyc.delete();
    rst = 0; imem_req_ready = 1; inst_ready = 1;
    repeat (12) tick();
    chk("stream_logged", 32'(req_log.size() >= 3 && hs_cyc.size() >= 2), 32'd1);
    if (req_log.size() >= 3 && hs_cyc.size() >= 2) begin
      chk("stream_req0", req_log[0], 32'h8000_0000);
      chk("stream_req1", req_log[1], 32'h8000_0004);
      chk("stream_req2", req_log[2], 32'h8000_0008);
      chk("stream_req_period", 32'(req_cyc[1] - req_cyc[0]), 32'd3);
      chk("stream_first_latency", 32'(hs_cyc[0] - req_cyc[0]), 32'd2);
      chk("stream_inst_period", 32'(hs_cyc[1] - hs_cyc[0]), 32'd3);
    end

    // Decode stall in HOLD
    inst_ready = 0;
    wait_inst();
    chk("stall_sb_depth", 32'(exp_q.size()), 32'd1);
    hold_pc   = exp_q.size() > 0 ? exp_q[0].pc : 32'hx;
    hold_inst = exp_q.size() > 0 ? exp_q[0].inst : 32'hx;
    for (int i = 0; i < 5; i++) begin
      chk("stall_inst_valid", 32'(inst_valid), 32'd1);
      chk("stall_inst_pc", inst_pc, hold_pc);
      chk("stall_inst", inst, hold_inst);
      chk("stall_no_req", 32'(imem_req_valid), 32'd0);
      @(negedge clk);
    end
    tick();
    inst_ready = 1;
    wait_req(a);
    chk("stall_resume_addr", a, hold_pc + 32'd4);

    // Redirect in WAIT, stale response three cycles later
    rsp_lat = 4;
    wait_req(a);
    tick();
    redirect = 1; redirect_pc = 32'h8000_0100;
    tick();
    redirect = 0;
    gap = 0; ivs = 0; got = 0;
    for (int n = 0; n < 30 && !got; n++) begin
      @(negedge clk);
      if (imem_req_valid) got = 1;
      else begin
        gap++;
        if (inst_valid) ivs++;
      end
    end
    chk("wait_redir_req_seen", 32'(got), 32'd1);
    chk("wait_redir_addr", imem_req_addr, 32'h8000_0100);
    chk("wait_redir_gap", 32'(gap), 32'd3);
    chk("wait_redir_no_stale_inst", 32'(ivs), 32'd0);

    // Redirect in the same cycle as the response
    rsp_lat = 1;
    wait_req(a);
    tick();
    redirect = 1; redirect_pc = 32'h8000_0300;
    tick();
    redirect = 0;
    chk("same_cyc_req_valid", 32'(imem_req_valid), 32'd1);
    chk("same_cyc_req_addr", imem_req_addr, 32'h8000_0300);
    chk("same_cyc_no_inst", 32'(inst_valid), 32'd0);

    // Redirect vector table
    foreach (vecs[i]) begin
      tick();
      err_addr = vecs[i].err;
      rsp_lat  = vecs[i].lat;
      redirect = 1; redirect_pc = vecs[i].pc;
      tick();
      redirect = 0;
      wait_inst();
      chk("vec_inst_pc", inst_pc, vecs[i].pc);
      chk("vec_inst", inst, vecs[i].exp_inst);
      chk("vec_inst_fault", 32'(inst_fault), 32'(vecs[i].exp_fault));
      tick();
      wait_req(a);
      chk("vec_next_addr", a, vecs[i].exp_next);
    end

    // Misaligned redirect: fault held until the next redirect
    err_addr = 32'hFFFF_FFF0;
    rsp_lat  = 1;
    wait_inst();
    tick();
    imem_req_ready = 0;
    redirect = 1; redirect_pc = 32'h8000_0102; mis_hold = 1;
    tick();
    redirect = 0; imem_req_ready = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("mis_no_req", 32'(imem_req_valid), 32'd0);
      if (i > 0) begin
        chk("mis_inst_valid", 32'(inst_valid), 32'd1);
        chk("mis_inst_pc", inst_pc, 32'h8000_0102);
        chk("mis_inst_fault", 32'(inst_fault), 32'd1);
        chk("mis_inst", inst, 32'd0);
      end
    end
    tick();
    redirect = 1; redirect_pc = 32'h8000_0200; mis_hold = 0;
    tick();
    redirect = 0;
    chk("mis_exit_req_valid", 32'(imem_req_valid), 32'd1);
    chk("mis_exit_req_addr", imem_req_addr, 32'h8000_0200);
    chk("mis_exit_inst_valid", 32'(inst_valid), 32'd0);

    // Reset in WAIT; the late response must be ignored
    rsp_lat = 3;
    wait_req(a);
    tick();
    imem_req_ready = 0;
    rst = 1;
    #1;
    chk("midrst_inst_valid", 32'(inst_valid), 32'd0);
    chk("midrst_req_addr", imem_req_addr, 32'h8000_0000);
    chk("midrst_inst_fault", 32'(inst_fault), 32'd0);
    tick();
    rst = 0;
    ivs = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (inst_valid) ivs++;
    end
    chk("midrst_stale_ignored", 32'(ivs), 32'd0);
    chk("midrst_still_req", 32'(imem_req_valid), 32'd1);
    tick();
    imem_req_ready = 1;
    wait_req(a);
    chk("midrst_first_addr", a, 32'h8000_0000);
    wait_inst();
    chk("midrst_first_pc", inst_pc, 32'h8000_0000);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
